// File: rtl/pixel_cfg_pkg.sv
// Shared configuration for the pixel-chip frame capture path.
//   K28_5         : default frame header byte (K28.5 comma, 0xBC)
//   cap_state_t   : capture FSM state encoding
//   word_bytes()  : bytes packed into one FIFO word
package pixel_cfg_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FINISH  = 2'd3
  } cap_state_t;

  function automatic int word_bytes(input int fifo_w, input int byte_w);
    return fifo_w / byte_w;
  endfunction

endpackage

// File: rtl/frame_aligner.sv
// Frame aligner: tracks the byte position inside a frame and locks onto the
// periodic header byte.
//   clk, rst_n   : clock, synchronous active-low reset
//   din          : incoming parallel byte
//   locked       : registered, alignment held
//   frame_start  : header byte sampled at position 0 while locked
//   frame_end    : last byte of a frame sampled while locked
//   sync_err     : non-header byte at position 0 while locked (lock drops
//                  on the following cycle)
module frame_aligner
  import pixel_cfg_pkg::*;
#(
  parameter int                BYTE_W      = 8,
  parameter int                FRAME_BYTES = 48,
  parameter int                SYNC_FRAMES = 2,
  parameter logic [BYTE_W-1:0] HEADER      = BYTE_W'(K28_5)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] din,
  output logic              locked,
  output logic              frame_start,
  output logic              frame_end,
  output logic              sync_err
);

  localparam int POS_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int CNT_W = $clog2(SYNC_FRAMES + 1);
  localparam logic [POS_W-1:0] LAST_POS      = POS_W'(FRAME_BYTES - 1);
  localparam logic [POS_W-1:0] POS_AFTER_HDR = (FRAME_BYTES > 1) ? POS_W'(1) : '0;
  localparam logic [CNT_W-1:0] SYNC_N        = CNT_W'(SYNC_FRAMES);

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_next;
  logic [CNT_W-1:0] hdr_ok;
  logic [CNT_W-1:0] hdr_inc;
  logic             is_hdr;
  logic             at_zero;

  assign is_hdr   = (din == HEADER);
  assign at_zero  = (pos == '0);
  assign pos_next = (pos == LAST_POS) ? '0 : pos + POS_W'(1);
  assign hdr_inc  = hdr_ok + CNT_W'(1);

  assign frame_start = locked & at_zero & is_hdr;
  assign frame_end   = locked & (pos == LAST_POS);
  assign sync_err    = locked & at_zero & ~is_hdr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos    <= '0;
      hdr_ok <= '0;
      locked <= 1'b0;
    end else if (locked) begin
      // Headers away from position 0 are payload; only position 0 matters.
      pos <= pos_next;
      if (sync_err) begin
        locked <= 1'b0;
        hdr_ok <= '0;
      end
    end else if (hdr_ok == '0) begin
      // Not tracking yet: any header byte defines the frame phase.
      pos <= pos_next;
      if (is_hdr) begin
        pos    <= POS_AFTER_HDR;
        hdr_ok <= CNT_W'(1);
        if (SYNC_N == CNT_W'(1)) locked <= 1'b1;
      end
    end else begin
      pos <= pos_next;
      if (at_zero) begin
        if (is_hdr) begin
          hdr_ok <= hdr_inc;
          if (hdr_inc == SYNC_N) locked <= 1'b1;
        end else begin
          hdr_ok <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/frame_capture_pkt.sv
// Pixel-chip frame capture: aligns to the frame header and packs a counted
// number of frames (or a continuous stream) into FIFO words, first byte in
// the most significant position.
//   clk, rst_n   : clock, synchronous active-low reset
//   din          : parallel pixel data, din[BYTE_W-1] is fd0
//   start/stop   : single-cycle capture request / continuous-mode stop
//   mode         : 0 counted (n_frames, 0 means 1), 1 continuous
//   fifo_full    : readout FIFO full flag
//   fifo_wr_en   : one-cycle write strobe with fifo_din
//   locked, busy, done, lock_lost, overflow, frames_done : status
module frame_capture_pkt
  import pixel_cfg_pkg::*;
#(
  parameter int                BYTE_W      = 8,
  parameter int                FIFO_WIDTH  = 32,
  parameter int                FRAME_BYTES = 48,
  parameter int                NFRAME_W    = 16,
  parameter int                SYNC_FRAMES = 2,
  parameter logic [BYTE_W-1:0] HEADER      = BYTE_W'(K28_5)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BYTE_W-1:0]     din,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [NFRAME_W-1:0]   n_frames,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] fifo_din,
  output logic                  locked,
  output logic                  busy,
  output logic                  done,
  output logic                  lock_lost,
  output logic                  overflow,
  output logic [NFRAME_W-1:0]   frames_done
);

  localparam int WB   = word_bytes(FIFO_WIDTH, BYTE_W);
  localparam int WC_W = (WB > 1) ? $clog2(WB) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WB - 1);

  if ((FIFO_WIDTH % BYTE_W) != 0) begin : g_chk_fifo_width
    $error("FIFO_WIDTH must be a multiple of BYTE_W");
  end
  if ((FRAME_BYTES % WB) != 0) begin : g_chk_frame_bytes
    $error("FRAME_BYTES must be a multiple of FIFO_WIDTH/BYTE_W");
  end
  if (SYNC_FRAMES < 1) begin : g_chk_sync
    $error("SYNC_FRAMES must be at least 1");
  end

  logic frame_start;
  logic frame_end;
  logic sync_err;

  frame_aligner #(
    .BYTE_W      (BYTE_W),
    .FRAME_BYTES (FRAME_BYTES),
    .SYNC_FRAMES (SYNC_FRAMES),
    .HEADER      (HEADER)
  ) u_aligner (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .locked      (locked),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .sync_err    (sync_err)
  );

  cap_state_t            state;
  logic                  mode_lat;
  logic [NFRAME_W-1:0]   n_lat;
  logic                  stop_seen;
  logic [WC_W-1:0]       wcnt;
  logic [FIFO_WIDTH-1:0] sreg;
  logic [FIFO_WIDTH-1:0] word_next;
  logic [NFRAME_W-1:0]   frames_inc;
  logic                  take;
  logic                  word_done;
  logic                  frame_done_now;
  logic                  last_frame;

  // Byte accepted into the packer: the aligned header that opens a capture,
  // then every byte until the capture ends. A byte that breaks sync is never
  // packed, so the word it would have started is discarded.
  assign take = ((state == ST_ARMED)   & frame_start) |
                ((state == ST_CAPTURE) & ~sync_err);

  assign word_next      = (sreg << BYTE_W) | FIFO_WIDTH'(din);
  assign word_done      = take & (wcnt == WC_LAST);
  assign frame_done_now = take & frame_end;
  assign frames_inc     = (frames_done == '1) ? frames_done
                                              : frames_done + NFRAME_W'(1);
  assign last_frame     = frame_done_now &
                          (mode_lat ? (stop_seen | stop) : (frames_inc == n_lat));

  // Packing shift register: data only, always fully overwritten per word.
  always_ff @(posedge clk) begin
    if (take) sreg <= word_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_lat    <= 1'b0;
      n_lat       <= '0;
      stop_seen   <= 1'b0;
      wcnt        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lock_lost   <= 1'b0;
      overflow    <= 1'b0;
      frames_done <= '0;
      fifo_wr_en  <= 1'b0;
      fifo_din    <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      done       <= 1'b0;

      case (state)
        ST_IDLE: begin
          // stop arriving with start is deliberately not latched.
          if (start) begin
            mode_lat    <= mode;
            n_lat       <= (n_frames == '0) ? NFRAME_W'(1) : n_frames;
            stop_seen   <= 1'b0;
            lock_lost   <= 1'b0;
            overflow    <= 1'b0;
            frames_done <= '0;
            wcnt        <= '0;
            busy        <= 1'b1;
            state       <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (mode_lat && stop) stop_seen <= 1'b1;
          if (sync_err) begin
            lock_lost <= 1'b1;
            state     <= ST_FINISH;
          end else if (last_frame) begin
            state <= ST_FINISH;
          end else if (frame_start) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (mode_lat && stop) stop_seen <= 1'b1;
          if (sync_err) begin
            lock_lost <= 1'b1;
            wcnt      <= '0;
            state     <= ST_FINISH;
          end else if (last_frame) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Word completion and frame accounting for accepted bytes.
      if (take) begin
        wcnt <= word_done ? '0 : wcnt + WC_W'(1);
        if (word_done) begin
          if (fifo_full) begin
            overflow <= 1'b1;
          end else begin
            fifo_wr_en <= 1'b1;
            fifo_din   <= word_next;
          end
        end
        if (frame_done_now) frames_done <= frames_inc;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_pkt.sv
module tb_frame_capture_pkt;

  localparam logic [7:0] HDR = 8'hBC;
  localparam int FB = 48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        start, stop, mode, fifo_full;
  logic [15:0] n_frames;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        locked, busy, done, lock_lost, overflow;
  logic [15:0] frames_done;

  frame_capture_pkt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .n_frames    (n_frames),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .locked      (locked),
    .busy        (busy),
    .done        (done),
    .lock_lost   (lock_lost),
    .overflow    (overflow),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] acc;
  int cap_idx, full_lo, full_hi;
  int wr_cnt, done_cnt, first_wr_cyc, last_wr_cyc, done_cyc, hdr_cyc;
  int fid = 0;

  typedef struct packed {
    int  mode;
    int  n;
    int  n_send;
    int  exp_frames;
    int  corrupt_k;
    int  stop_k;
    int  full_word;
    int  restart_k;
    int  exp_writes;
    int  exp_ovf;
    int  exp_ll;
  } case_t;

  case_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobed word must match the oldest expected word.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got=%0h want=no write", fifo_din);
      end else begin
        check("fifo_word", fifo_din, exp_q.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [7:0] fbyte(input int f, input int i);
    logic [7:0] b;
    if (i == 0) return HDR;
    b = 8'((f * 11 + i * 3) & 255);
    if (b == HDR) b = 8'h3C;
    return b;
  endfunction

  task automatic drive_byte(input logic [7:0] b, input bit cap);
    din       = b;
    fifo_full = cap && (cap_idx >= full_lo) && (cap_idx < full_hi);
    if (cap) begin
      acc = {acc[23:0], b};
      if ((cap_idx % 4) == 3 && !fifo_full) exp_q.push_back(acc);
    end
    @(posedge clk);
    #1;
    if (cap) begin
      if (cap_idx == 0) hdr_cyc = cyc;
      cap_idx++;
    end
    start     = 1'b0;
    stop      = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic drive_frame(input bit cap, input bit corrupt, input int start_at, input int stop_at);
    logic [7:0] b;
    for (int i = 0; i < FB; i++) begin
      b = fbyte(fid, i);
      if (i == 0 && corrupt) b = 8'h00;
      if (i == start_at) start = 1'b1;
      if (i == stop_at) stop = 1'b1;
      drive_byte(b, cap && !corrupt);
    end
    fid++;
  endtask

  task automatic clear_counts();
    cap_idx = 0; wr_cnt = 0; done_cnt = 0;
    first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1; hdr_cyc = -1;
    full_lo = 0; full_hi = 0;
  endtask

  task automatic run_case(input int idx);
    case_t r;
    r = tbl[idx];
    clear_counts();
    mode     = r.mode[0];
    n_frames = 16'(r.n);
    if (r.full_word >= 0) begin
      full_lo = r.full_word * 4;
      full_hi = full_lo + 8;
    end
    check($sformatf("c%0d_locked_pre", idx), 32'(locked), 32'd1);
    // start mid-frame; in continuous mode stop rides along and must be ignored
    drive_frame(1'b0, 1'b0, 10, (r.mode != 0) ? 10 : -1);
    check($sformatf("c%0d_busy_armed", idx), 32'(busy), 32'd1);
    for (int k = 0; k < r.n_send; k++) begin
      if (k == r.restart_k) n_frames = 16'd1;
      drive_frame(k < r.exp_frames, k == r.corrupt_k,
                  (k == r.restart_k) ? 30 : -1, (k == r.stop_k) ? 20 : -1);
      if (k == r.restart_k) begin
        check($sformatf("c%0d_ovf_after_restart", idx), 32'(overflow), 32'(r.exp_ovf));
        check($sformatf("c%0d_busy_after_restart", idx), 32'(busy), 32'd1);
      end
      if (k == r.corrupt_k) begin
        check($sformatf("c%0d_locked_fell", idx), 32'(locked), 32'd0);
        check($sformatf("c%0d_lock_lost_set", idx), 32'(lock_lost), 32'd1);
      end
    end
    for (int k = 0; k < 3; k++) drive_frame(1'b0, 1'b0, -1, -1);
    check($sformatf("c%0d_writes", idx), 32'(wr_cnt), 32'(r.exp_writes));
    check($sformatf("c%0d_done_pulses", idx), 32'(done_cnt), 32'd1);
    check($sformatf("c%0d_frames_done", idx), 32'(frames_done), 32'(r.exp_frames));
    check($sformatf("c%0d_overflow", idx), 32'(overflow), 32'(r.exp_ovf));
    check($sformatf("c%0d_lock_lost", idx), 32'(lock_lost), 32'(r.exp_ll));
    check($sformatf("c%0d_busy_end", idx), 32'(busy), 32'd0);
    check($sformatf("c%0d_queue_left", idx), 32'(exp_q.size()), 32'd0);
    if (r.exp_ll == 0)
      check($sformatf("c%0d_done_latency", idx), 32'(done_cyc), 32'(last_wr_cyc + 1));
    if (idx == 0)
      check("first_write_latency", 32'(first_wr_cyc), 32'(hdr_cyc + 3));
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{mode:0, n:3, n_send:3, exp_frames:3, corrupt_k:-1, stop_k:-1,
               full_word:-1, restart_k:-1, exp_writes:36, exp_ovf:0, exp_ll:0};
    tbl[1] = '{mode:0, n:3, n_send:3, exp_frames:3, corrupt_k:-1, stop_k:-1,
               full_word:5, restart_k:1, exp_writes:34, exp_ovf:1, exp_ll:0};
    tbl[2] = '{mode:1, n:2, n_send:5, exp_frames:4, corrupt_k:-1, stop_k:3,
               full_word:-1, restart_k:-1, exp_writes:48, exp_ovf:0, exp_ll:0};
    tbl[3] = '{mode:0, n:0, n_send:1, exp_frames:1, corrupt_k:-1, stop_k:-1,
               full_word:-1, restart_k:-1, exp_writes:12, exp_ovf:0, exp_ll:0};
    tbl[4] = '{mode:0, n:2, n_send:2, exp_frames:2, corrupt_k:-1, stop_k:0,
               full_word:-1, restart_k:-1, exp_writes:24, exp_ovf:0, exp_ll:0};
    tbl[5] = '{mode:0, n:5, n_send:5, exp_frames:1, corrupt_k:1, stop_k:-1,
               full_word:-1, restart_k:-1, exp_writes:12, exp_ovf:0, exp_ll:1};

    rst_n = 1'b0; din = 8'h00; start = 1'b0; stop = 1'b0; mode = 1'b0;
    n_frames = 16'd0; fifo_full = 1'b0; acc = '0;
    clear_counts();

    // Reset state
    for (int i = 0; i < 3; i++) drive_byte(8'h00, 1'b0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_frames_done", 32'(frames_done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive_byte(8'h00, 1'b0);

    // Lock acquisition: rises right after the second aligned header
    drive_frame(1'b0, 1'b0, -1, -1);
    check("lock_before_2nd_hdr", 32'(locked), 32'd0);
    drive_byte(HDR, 1'b0);
    check("lock_after_2nd_hdr", 32'(locked), 32'd1);
    for (int i = 1; i < FB; i++) drive_byte(fbyte(fid, i), 1'b0);
    fid++;
    drive_frame(1'b0, 1'b0, -1, -1);
    check("lock_holds", 32'(locked), 32'd1);

    for (int c = 0; c < 6; c++) run_case(c);

    // Reset mid-capture: first word dropped (overflow), reset mid second word
    clear_counts();
    full_lo = 0; full_hi = 4;
    mode = 1'b0; n_frames = 16'd2;
    drive_frame(1'b0, 1'b0, 10, -1);
    for (int i = 0; i < 6; i++) drive_byte(fbyte(fid, i), 1'b1);
    check("pre_reset_overflow", 32'(overflow), 32'd1);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    drive_byte(fbyte(fid, 6), 1'b1);
    rst_n = 1'b1;
    check("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("midrst_fifo_din", fifo_din, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_lock_lost", 32'(lock_lost), 32'd0);
    check("midrst_frames_done", 32'(frames_done), 32'd0);
    for (int i = 7; i < FB; i++) drive_byte(fbyte(fid, i), 1'b0);
    fid++;
    for (int k = 0; k < 3; k++) drive_frame(1'b0, 1'b0, -1, -1);
    check("post_rst_writes", 32'(wr_cnt), 32'd0);
    check("post_rst_done", 32'(done_cnt), 32'd0);
    check("post_rst_relock", 32'(locked), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
